exe_stage_pipe: RTL

EXE_STAGE_PIPE -- requirements
Module: exe_stage_pipe

---
 rtl/exe_stage_pipe.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage_pipe.sv
// Execute stage: single-cycle ALU and branch-target adder, plus a multi-cycle
// shift-add multiplier. All results go to one output register with freeze/flush control.
module exe_stage_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 24,
  parameter int unsigned MUL_BPC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        exe_cmd,
  input  logic              mul_en,
  input  logic              s_in,
  input  logic              br_en_in,
  input  logic              mem_read_en_in,
  input  logic              mem_write_en_in,
  input  logic              wb_en_in,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_2,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [IMM_W-1:0]  signed_imm,
  input  logic [3:0]        dest_in,
  output logic              busy,
  output logic              out_valid,
  output logic              br_taken,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic              wb_en,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] br_addr,
  output logic [DATA_W-1:0] val_rm,
  output logic [3:0]        dest,
  output logic [3:0]        status_reg
);

  localparam int unsigned STEPS = DATA_W / MUL_BPC;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  typedef struct packed {
    logic       br;
    logic       mr;
    logic       mw;
    logic       wb;
    logic       s;
    logic [3:0] dest;
  } ctrl_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplr_q, mplr_d;
  ctrl_t             lat_q, lat_d;
  logic [DATA_W-1:0] lat_rm_q, lat_rm_d, lat_ba_q, lat_ba_d;

  logic              out_valid_q, out_valid_d, br_taken_q, br_taken_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d, wb_en_q, wb_en_d;
  logic [DATA_W-1:0] alu_res_q, alu_res_d, br_addr_q, br_addr_d, val_rm_q, val_rm_d;
  logic [3:0]        dest_q, dest_d, status_q, status_d;

  logic [DATA_W-1:0] b_op, alu_val, imm_ext, br_calc, pp;
  logic [DATA_W:0]   sum;
  logic              cin, arith, known, v_new, accept;
  logic [3:0]        alu_flags;

  // Subtracts are done as rn + ~op + cin so carry-out is the ARM no-borrow flag.
  always_comb begin
    b_op  = val_2;
    cin   = 1'b0;
    arith = 1'b0;
    case (exe_cmd)
      4'b0010: arith = 1'b1;
      4'b0011: begin arith = 1'b1; cin = status_q[1]; end
      4'b0100: begin arith = 1'b1; b_op = ~val_2; cin = 1'b1; end
      4'b0101: begin arith = 1'b1; b_op = ~val_2; cin = status_q[1]; end
      default: ;
    endcase
    sum   = {1'b0, val_rn} + {1'b0, b_op} + {{DATA_W{1'b0}}, cin};
    v_new = (val_rn[DATA_W-1] == b_op[DATA_W-1]) && (sum[DATA_W-1] != val_rn[DATA_W-1]);
    known = 1'b1;
    case (exe_cmd)
      4'b0001: alu_val = val_2;
      4'b1001: alu_val = ~val_2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: alu_val = sum[DATA_W-1:0];
      4'b0110: alu_val = val_rn & val_2;
      4'b0111: alu_val = val_rn | val_2;
      4'b1000: alu_val = val_rn ^ val_2;
      default: begin alu_val = '0; known = 1'b0; end
    endcase
    alu_flags = {alu_val[DATA_W-1], alu_val == '0,
                 arith ? sum[DATA_W] : status_q[1],
                 arith ? v_new : status_q[0]};
    imm_ext = {{(DATA_W-IMM_W){signed_imm[IMM_W-1]}}, signed_imm};
    br_calc = pc + (imm_ext << 2);
  end

  always_comb begin
    pp = '0;
    for (int unsigned j = 0; j < MUL_BPC; j++)
      if (mplr_q[j]) pp = pp + (mcand_q << j);
  end

  assign accept = in_valid && (state_q == S_IDLE) && !freeze;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    lat_d    = lat_q;
    lat_rm_d = lat_rm_q;
    lat_ba_d = lat_ba_q;
    case (state_q)
      S_IDLE: if (accept && mul_en && !flush) begin
        state_d  = S_MUL;
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = val_rn;
        mplr_d   = val_2;
        lat_d    = '{br: br_en_in, mr: mem_read_en_in, mw: mem_write_en_in,
                     wb: wb_en_in, s: s_in, dest: dest_in};
        lat_rm_d = val_rm_in;
        lat_ba_d = br_calc;
      end
      S_MUL: begin
        acc_d   = acc_q + pp;
        mcand_d = mcand_q << MUL_BPC;
        mplr_d  = mplr_q >> MUL_BPC;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(STEPS - 1)) state_d = S_DONE;
      end
      S_DONE: if (!freeze) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && !freeze) state_d = S_IDLE;
  end

  // Output register: freeze > flush > multiplier retire > ALU accept > bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    br_taken_d  = br_taken_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    wb_en_d     = wb_en_q;
    alu_res_d   = alu_res_q;
    br_addr_d   = br_addr_q;
    val_rm_d    = val_rm_q;
    dest_d      = dest_q;
    status_d    = status_q;
    if (!freeze) begin
      out_valid_d = 1'b0;
      br_taken_d  = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      wb_en_d     = 1'b0;
      if (flush) begin
      end else if (state_q == S_DONE) begin
        out_valid_d = 1'b1;
        br_taken_d  = lat_q.br;
        mem_read_d  = lat_q.mr;
        mem_write_d = lat_q.mw;
        wb_en_d     = lat_q.wb;
        alu_res_d   = acc_q;
        br_addr_d   = lat_ba_q;
        val_rm_d    = lat_rm_q;
        dest_d      = lat_q.dest;
        if (lat_q.s) status_d = {acc_q[DATA_W-1], acc_q == '0, status_q[1:0]};
      end else if (accept && !mul_en) begin
        out_valid_d = 1'b1;
        br_taken_d  = br_en_in;
        mem_read_d  = mem_read_en_in;
        mem_write_d = mem_write_en_in;
        wb_en_d     = wb_en_in;
        alu_res_d   = alu_val;
        br_addr_d   = br_calc;
        val_rm_d    = val_rm_in;
        dest_d      = dest_in;
        if (s_in && known) status_d = alu_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      lat_q       <= '0;
      lat_rm_q    <= '0;
      lat_ba_q    <= '0;
      out_valid_q <= 1'b0;
      br_taken_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wb_en_q     <= 1'b0;
      alu_res_q   <= '0;
      br_addr_q   <= '0;
      val_rm_q    <= '0;
      dest_q      <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      lat_q       <= lat_d;
      lat_rm_q    <= lat_rm_d;
      lat_ba_q    <= lat_ba_d;
      out_valid_q <= out_valid_d;
      br_taken_q  <= br_taken_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      wb_en_q     <= wb_en_d;
      alu_res_q   <= alu_res_d;
      br_addr_q   <= br_addr_d;
      val_rm_q    <= val_rm_d;
      dest_q      <= dest_d;
      status_q    <= status_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign out_valid    = out_valid_q;
  assign br_taken     = br_taken_q;
  assign mem_read_en  = mem_read_q;
  assign mem_write_en = mem_write_q;
  assign wb_en        = wb_en_q;
  assign alu_res      = alu_res_q;
  assign br_addr      = br_addr_q;
  assign val_rm       = val_rm_q;
  assign dest         = dest_q;
  assign status_reg   = status_q;

endmodule
